req_index_serializer: RTL and testbench

//   Sticky request collector and index issuer built around mxn_encoder.
//   - Accumulates one-hot/multi-hot request strobes into a pending register.
//   - Encodes the pending register by priority and issues one bit index per

---
 rtl/req_index_serializer_pkg.sv | 23 ++
 rtl/req_index_serializer_enc.sv | 33 +++
 rtl/req_index_serializer.sv | 99 +++++++++
 tb/tb_req_index_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/req_index_serializer_pkg.sv
// Shared types and helpers for the request index serializer.
// Combinational only; no latency, no flow control.
// No backpressure; pure declarations.
package req_ser_pkg;

    typedef enum logic {ST_EMPTY, ST_FULL} ser_state_t;

    // Widest request vector the one-hot helper can produce.
    localparam int unsigned ONEHOT_MAX_W = 256;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot_from_idx(
        input int unsigned idx,
        input int unsigned width
    );
        logic [ONEHOT_MAX_W-1:0] oh;
        oh = '0;
        if ((idx < width) && (idx < ONEHOT_MAX_W)) begin
            oh[idx[7:0]] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/req_index_serializer_enc.sv
// Priority encoder over a multi-hot vector: lowest or highest set bit wins.
// Combinational, zero latency.
// No backpressure; valid_out=0 when the input is all zero.
module mxn_encoder #(
    parameter int DATA_WIDTH    = 16,
    parameter int PRIORITY_TYPE = 0,
    localparam int IDX_W        = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [IDX_W-1:0]      encoded_data_out,
    output logic                  valid_out
);

    always_comb begin
        encoded_data_out = '0;
        valid_out        = |data_in;
        // Scan toward the winning end so the last hit is the highest-priority bit.
        if (PRIORITY_TYPE == 0) begin
            for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                if (data_in[i]) begin
                    encoded_data_out = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (data_in[i]) begin
                    encoded_data_out = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/req_index_serializer.sv
// Collects sticky request bits and issues them one index per handshake by fixed priority.
// Latency: strobe -> pending next cycle -> idx_valid the cycle after.
// Backpressure: idx_data held while idx_ready=0; new requests keep merging into pending.
module req_index_serializer
    import req_ser_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int PRIORITY_TYPE = 0,
    localparam int IDX_W        = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] req_in,
    input  logic                  req_in_vld,
    output logic [IDX_W-1:0]      idx_data,
    output logic                  idx_valid,
    input  logic                  idx_ready,
    output logic [DATA_WIDTH-1:0] pending_out,
    output logic                  busy,
    output logic                  overflow
);

    ser_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] pending_q, pending_d;
    logic                  ovf_q, ovf_d;

    logic [IDX_W-1:0]        enc_idx;
    logic                    enc_vld;
    logic                    accept;
    logic                    load;
    logic [ONEHOT_MAX_W-1:0] oh_full;
    logic [DATA_WIDTH-1:0]   served_mask;
    logic [DATA_WIDTH-1:0]   set_mask;
    logic                    unused_oh;

    mxn_encoder #(
        .DATA_WIDTH    (DATA_WIDTH),
        .PRIORITY_TYPE (PRIORITY_TYPE)
    ) u_enc (
        .data_in          (pending_q),
        .encoded_data_out (enc_idx),
        .valid_out        (enc_vld)
    );

    assign idx_valid = (state_q == ST_FULL);
    assign accept    = idx_valid & idx_ready;
    assign load      = ((state_q == ST_EMPTY) | accept) & enc_vld;

    assign oh_full     = onehot_from_idx(32'(enc_idx), DATA_WIDTH);
    assign unused_oh   = |oh_full[ONEHOT_MAX_W-1:DATA_WIDTH];
    assign served_mask = load ? oh_full[DATA_WIDTH-1:0] : '0;
    assign set_mask    = req_in_vld ? req_in : '0;

    // Set wins over serve, so a re-request of the bit being loaded stays pending.
    always_comb begin
        pending_d = (pending_q & ~served_mask) | set_mask;
        ovf_d     = req_in_vld & (|(req_in & pending_q & ~served_mask));
        if (flush) begin
            pending_d = '0;
            ovf_d     = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = ST_EMPTY;
            idx_d   = '0;
        end else if (load) begin
            state_d = ST_FULL;
            idx_d   = enc_idx;
        end else if (accept) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            idx_q     <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign idx_data    = idx_q;
    assign pending_out = pending_q;
    assign overflow    = ovf_q;
    assign busy        = (|pending_q) | idx_valid;

endmodule

// File: tb/tb_req_index_serializer.sv
// Scoreboard bench: stimulus pushes expected indices, monitors pop on each handshake.
module tb_req_index_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        flush0 = 1'b0, vld0 = 1'b0, rdy0 = 1'b0;
    logic [15:0] req0 = '0;
    logic [3:0]  idx0;
    logic        ival0, busy0, ovf0;
    logic [15:0] pend0;

    logic        flush1 = 1'b0, vld1 = 1'b0, rdy1 = 1'b0;
    logic [15:0] req1 = '0;
    logic [3:0]  idx1;
    logic        ival1, busy1, ovf1;
    logic [15:0] pend1;

    int n_run = 0;
    int n_fail = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    req_index_serializer #(.DATA_WIDTH(16), .PRIORITY_TYPE(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .req_in(req0), .req_in_vld(vld0),
        .idx_data(idx0), .idx_valid(ival0), .idx_ready(rdy0),
        .pending_out(pend0), .busy(busy0), .overflow(ovf0)
    );

    req_index_serializer #(.DATA_WIDTH(16), .PRIORITY_TYPE(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .req_in(req1), .req_in_vld(vld1),
        .idx_data(idx1), .idx_valid(ival1), .idx_ready(rdy1),
        .pending_out(pend1), .busy(busy1), .overflow(ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ival0 && rdy0) begin
            n_run++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL lsb_unexpected: got idx %0d expected none", idx0);
            end else begin
                int e;
                e = q0.pop_front();
                if (int'(idx0) != e) begin
                    n_fail++;
                    $display("FAIL lsb_idx: got %0d expected %0d", idx0, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ival1 && rdy1) begin
            n_run++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL msb_unexpected: got idx %0d expected none", idx1);
            end else begin
                int e;
                e = q1.pop_front();
                if (int'(idx1) != e) begin
                    n_fail++;
                    $display("FAIL msb_idx: got %0d expected %0d", idx1, e);
                end
            end
        end
    end

    initial begin
        // Reset state
        step(2);
        chk("rst_valid", 32'(ival0), 0);
        chk("rst_idx", 32'(idx0), 0);
        chk("rst_pending", 32'(pend0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        rst_n = 1'b1;
        step(1);

        // Single request
        rdy0 = 1'b1;
        req0 = 16'h0020; vld0 = 1'b1; q0.push_back(5);
        step(1);
        vld0 = 1'b0; req0 = '0;
        chk("single_pend", 32'(pend0), 32'h0020);
        chk("single_notyet", 32'(ival0), 0);
        step(1);
        chk("single_valid", 32'(ival0), 1);
        chk("single_pend_clr", 32'(pend0), 0);
        step(1);
        chk("single_done_valid", 32'(ival0), 0);
        chk("single_done_busy", 32'(busy0), 0);

        // LSB-first burst
        req0 = 16'h8421; vld0 = 1'b1;
        q0.push_back(0); q0.push_back(5); q0.push_back(10); q0.push_back(15);
        step(1);
        vld0 = 1'b0; req0 = '0;
        step(1);
        chk("burst_first_valid", 32'(ival0), 1);
        step(4);
        chk("burst_end_valid", 32'(ival0), 0);
        chk("burst_end_busy", 32'(busy0), 0);

        // MSB-first under backpressure
        rdy1 = 1'b0;
        req1 = 16'h0003; vld1 = 1'b1;
        q1.push_back(1); q1.push_back(0);
        step(1);
        vld1 = 1'b0; req1 = '0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_valid", 32'(ival1), 1);
            chk("bp_idx_hold", 32'(idx1), 1);
        end
        rdy1 = 1'b1;
        step(2);
        chk("bp_drained", 32'(ival1), 0);
        chk("bp_busy", 32'(busy1), 0);

        // Overflow: bit 3 waits behind idx 0 while stalled
        rdy0 = 1'b0;
        req0 = 16'h0009; vld0 = 1'b1;
        q0.push_back(0); q0.push_back(3);
        step(1);
        vld0 = 1'b0; req0 = '0;
        step(1);
        chk("ovf_pend", 32'(pend0), 32'h0008);
        chk("ovf_pre", 32'(ovf0), 0);
        req0 = 16'h0008; vld0 = 1'b1;
        step(1);
        vld0 = 1'b0; req0 = '0;
        chk("ovf_pulse", 32'(ovf0), 1);
        step(1);
        chk("ovf_clear", 32'(ovf0), 0);
        rdy0 = 1'b1;
        step(4);
        chk("ovf_drained", 32'(busy0), 0);

        // Serve and re-request the same bit in one cycle
        req0 = 16'h0080; vld0 = 1'b1;
        q0.push_back(7); q0.push_back(7);
        step(1);
        chk("rereq_pend", 32'(pend0), 32'h0080);
        step(1);
        vld0 = 1'b0; req0 = '0;
        chk("rereq_no_ovf", 32'(ovf0), 0);
        chk("rereq_still_pend", 32'(pend0), 32'h0080);
        chk("rereq_valid", 32'(ival0), 1);
        step(3);
        chk("rereq_done", 32'(busy0), 0);

        // Flush mid-stream; a simultaneous re-request of a pending bit is dropped
        req0 = 16'hFFFF; vld0 = 1'b1;
        q0.push_back(0); q0.push_back(1); q0.push_back(2);
        step(1);
        vld0 = 1'b0; req0 = '0;
        step(3);
        flush0 = 1'b1; req0 = 16'h8000; vld0 = 1'b1;
        step(1);
        flush0 = 1'b0; vld0 = 1'b0; req0 = '0;
        chk("flush_valid", 32'(ival0), 0);
        chk("flush_pend", 32'(pend0), 0);
        chk("flush_ovf", 32'(ovf0), 0);
        step(1);
        chk("flush_stays_idle", 32'(busy0), 0);

        // Asynchronous reset mid-stream
        req0 = 16'hFFFF; vld0 = 1'b1;
        q0.push_back(0); q0.push_back(1);
        step(1);
        vld0 = 1'b0; req0 = '0;
        step(3);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ival0), 0);
        chk("arst_idx", 32'(idx0), 0);
        chk("arst_pend", 32'(pend0), 0);
        chk("arst_busy", 32'(busy0), 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("arst_no_replay", 32'(ival0), 0);
        chk("arst_idle", 32'(busy0), 0);

        chk("lsb_queue_empty", 32'(q0.size()), 0);
        chk("msb_queue_empty", 32'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
